// File: rtl/sdc_pll_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package sdc_pll_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  localparam int RETRY_W = 4;

  typedef struct packed {
    logic pll_reset;
    logic sys_reset;
    logic locked;
    logic fail;
  } mon_out_t;

  // Width that holds terminal count N-1 for the largest of the three limits.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdc_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module sdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= '0;
    else     ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/sdc_pll_lock_mon.sv
// PLL lock supervisor on refclk: sequences PLL reset, qualifies lock with a
// timeout and bounded retries, and gates the system reset on stable lock.
module sdc_pll_lock_mon
  import sdc_pll_pkg::*;
#(
  parameter int RST_CYC    = 16,
  parameter int LOCK_TMO   = 24000,
  parameter int STABLE_CYC = 256,
  parameter int MAX_RETRY  = 3
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic               extlock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic               sys_reset,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = cnt_w(RST_CYC, LOCK_TMO, STABLE_CYC);
  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [RETRY_W:0]   RETRY_LIM = (RETRY_W + 1)'(MAX_RETRY);

  logic lk_s;

  sdc_sync2 u_lock_sync (
    .clk (refclk),
    .rst (reset),
    .d   (extlock),
    .q   (lk_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  mon_out_t           out_q, out_d;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_q;

    if (relock_req) begin
      state_d   = S_RST;
      rst_cnt_d = '0;
      tmo_cnt_d = '0;
      stb_cnt_d = '0;
      retry_d   = '0;
    end else begin
      case (state_q)
        S_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = S_WAIT;
            rst_cnt_d = '0;
            tmo_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_WAIT, S_STABLE: begin
          // Timeout wins over lock transitions so a flickering lock still expires.
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d = '0;
            stb_cnt_d = '0;
            rst_cnt_d = '0;
            if (({1'b0, retry_q} + 1'b1) == RETRY_LIM) begin
              retry_d = RETRY_W'(MAX_RETRY);
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_RST;
            end
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (state_q == S_WAIT) begin
              if (lk_s) begin
                state_d   = S_STABLE;
                stb_cnt_d = '0;
              end
            end else if (!lk_s) begin
              state_d   = S_WAIT;
              stb_cnt_d = '0;
            end else if (stb_cnt_q == STB_LAST) begin
              state_d   = S_RUN;
              stb_cnt_d = '0;
              tmo_cnt_d = '0;
              retry_d   = '0;
            end else begin
              stb_cnt_d = stb_cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            state_d   = S_RST;
            rst_cnt_d = '0;
          end
        end
        S_FAIL: ;
        default: begin
          state_d   = S_RST;
          rst_cnt_d = '0;
        end
      endcase
    end

    out_d.pll_reset = (state_d == S_RST);
    out_d.sys_reset = (state_d != S_RUN);
    out_d.locked    = (state_d == S_RUN);
    out_d.fail      = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      stb_cnt_q <= '0;
      retry_q   <= '0;
      out_q     <= '{pll_reset: 1'b1, sys_reset: 1'b1, locked: 1'b0, fail: 1'b0};
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      retry_q   <= retry_d;
      out_q     <= out_d;
    end
  end

  assign pll_reset = out_q.pll_reset;
  assign sys_reset = out_q.sys_reset;
  assign locked    = out_q.locked;
  assign fail      = out_q.fail;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_sdc_pll_lock_mon.sv
// Directed bench for sdc_pll_lock_mon; observes {pll_reset,sys_reset,locked,fail,retry_cnt}.
module tb_sdc_pll_lock_mon;

  logic       refclk = 1'b0;
  logic       reset, extlock, relock_req;
  logic       pll_reset, sys_reset, locked, fail;
  logic [3:0] retry_cnt;
  logic [7:0] o;
  int         vec = 0;
  int         err = 0;

  always #5 refclk = ~refclk;

  sdc_pll_lock_mon #(
    .RST_CYC(4), .LOCK_TMO(20), .STABLE_CYC(8), .MAX_RETRY(2)
  ) dut (
    .refclk(refclk), .reset(reset), .extlock(extlock), .relock_req(relock_req),
    .pll_reset(pll_reset), .sys_reset(sys_reset), .locked(locked), .fail(fail),
    .retry_cnt(retry_cnt)
  );

  assign o = {pll_reset, sys_reset, locked, fail, retry_cnt};

  // Encodings: C0=RST r0, 40=WAIT r0, 20=RUN, C1=RST r1, 41=WAIT r1, 52=FAIL r2.
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; extlock = 1'b0; relock_req = 1'b0;
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL rst_hold: got %h exp %h", o, 8'hC0); end
    reset = 1'b0;
  endtask

  task automatic test_lock;
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL lock_pll_hi: got %h exp %h", o, 8'hC0); end
    step(1);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL lock_pll_fall: got %h exp %h", o, 8'h40); end
    step(3);
    extlock = 1'b1;
    step(10);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL lock_early: got %h exp %h", o, 8'h40); end
    step(1);
    vec++; if (o !== 8'h20) begin err++; $display("FAIL lock_run: got %h exp %h", o, 8'h20); end
  endtask

  task automatic test_lock_loss;
    extlock = 1'b0;
    step(1);
    extlock = 1'b1;
    step(1);
    vec++; if (o !== 8'h20) begin err++; $display("FAIL loss_lat: got %h exp %h", o, 8'h20); end
    step(1);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL loss_rst: got %h exp %h", o, 8'hC0); end
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL loss_pll_hi: got %h exp %h", o, 8'hC0); end
    step(1);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL loss_pll_fall: got %h exp %h", o, 8'h40); end
    step(8);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL loss_early: got %h exp %h", o, 8'h40); end
    step(1);
    vec++; if (o !== 8'h20) begin err++; $display("FAIL loss_relock: got %h exp %h", o, 8'h20); end
  endtask

  task automatic test_flicker;
    logic [7:0] exp;
    relock_req = 1'b1; extlock = 1'b0;
    step(1);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL flk_relock: got %h exp %h", o, 8'hC0); end
    relock_req = 1'b0;
    for (int i = 0; i < 24; i++) begin
      extlock = ((i / 5) % 2 == 0);
      step(1);
      exp = (i == 23) ? 8'hC1 : (i < 3) ? 8'hC0 : 8'h40;
      vec++; if (o !== exp) begin err++; $display("FAIL flk_step%0d: got %h exp %h", i, o, exp); end
    end
  endtask

  task automatic test_timeout_fail;
    extlock = 1'b0; relock_req = 1'b1;
    step(1);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL tmo_clear: got %h exp %h", o, 8'hC0); end
    relock_req = 1'b0;
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL tmo_pll_hi0: got %h exp %h", o, 8'hC0); end
    step(1);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL tmo_wait0: got %h exp %h", o, 8'h40); end
    step(19);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL tmo_pre1: got %h exp %h", o, 8'h40); end
    step(1);
    vec++; if (o !== 8'hC1) begin err++; $display("FAIL tmo_retry1: got %h exp %h", o, 8'hC1); end
    step(3);
    vec++; if (o !== 8'hC1) begin err++; $display("FAIL tmo_pll_hi1: got %h exp %h", o, 8'hC1); end
    step(1);
    vec++; if (o !== 8'h41) begin err++; $display("FAIL tmo_wait1: got %h exp %h", o, 8'h41); end
    step(19);
    vec++; if (o !== 8'h41) begin err++; $display("FAIL tmo_pre2: got %h exp %h", o, 8'h41); end
    step(1);
    vec++; if (o !== 8'h52) begin err++; $display("FAIL tmo_fail: got %h exp %h", o, 8'h52); end
    step(10);
    vec++; if (o !== 8'h52) begin err++; $display("FAIL tmo_fail_hold: got %h exp %h", o, 8'h52); end
  endtask

  task automatic test_fail_relock;
    relock_req = 1'b1;
    step(1);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL frl_exit: got %h exp %h", o, 8'hC0); end
    relock_req = 1'b0;
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL frl_pll_hi: got %h exp %h", o, 8'hC0); end
    step(1);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL frl_wait: got %h exp %h", o, 8'h40); end
    step(20);
    vec++; if (o !== 8'hC1) begin err++; $display("FAIL frl_retry1: got %h exp %h", o, 8'hC1); end
    step(4);
    vec++; if (o !== 8'h41) begin err++; $display("FAIL frl_wait1: got %h exp %h", o, 8'h41); end
    step(19);
    vec++; if (o !== 8'h41) begin err++; $display("FAIL frl_pre_tmo: got %h exp %h", o, 8'h41); end
    relock_req = 1'b1;
    step(1);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL frl_prio: got %h exp %h", o, 8'hC0); end
    relock_req = 1'b0;
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL frl_pll_hi2: got %h exp %h", o, 8'hC0); end
    step(1);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL frl_wait2: got %h exp %h", o, 8'h40); end
  endtask

  task automatic test_async_reset;
    step(20);
    vec++; if (o !== 8'hC1) begin err++; $display("FAIL ar_retry1: got %h exp %h", o, 8'hC1); end
    extlock = 1'b1;
    step(4);
    vec++; if (o !== 8'h41) begin err++; $display("FAIL ar_wait: got %h exp %h", o, 8'h41); end
    step(2);
    vec++; if (o !== 8'h41) begin err++; $display("FAIL ar_stable: got %h exp %h", o, 8'h41); end
    #3 reset = 1'b1;
    #1;
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL ar_async: got %h exp %h", o, 8'hC0); end
    step(2);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL ar_hold: got %h exp %h", o, 8'hC0); end
    reset = 1'b0;
    step(3);
    vec++; if (o !== 8'hC0) begin err++; $display("FAIL ar_pll_hi: got %h exp %h", o, 8'hC0); end
    step(1);
    vec++; if (o !== 8'h40) begin err++; $display("FAIL ar_pll_fall: got %h exp %h", o, 8'h40); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_lock_loss;
    test_flicker;
    test_timeout_fail;
    test_fail_relock;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/sdc_pll_lock_mon.md
Name: sdc_pll_lock_mon

Overview:
Lock supervisor for the system PLL. It drives the PLL reset input and consumes the PLL's extlock output. The block runs on the free-running reference clock, because the PLL output is not trustworthy before lock. It sequences PLL reset, waits for lock with a timeout and a bounded number of retries, and qualifies lock stability before releasing the system reset. On lock loss it re-resets the PLL and holds the system in reset.

Parameters:
RST_CYC, 16, refclk cycles pll_reset is held high per attempt (>=2)
LOCK_TMO, 24000, refclk cycles allowed from pll_reset release to a stable lock (1 ms at 24 MHz)
STABLE_CYC, 256, consecutive synced-extlock-high cycles required before release (>=1)
MAX_RETRY, 3, timed-out attempts allowed before FAIL (1..15)

Ports:
refclk  in  1  reference clock; same net as the PLL refclk
reset  in  1  asynchronous, active-high reset
extlock  in  1  PLL lock indicator; asynchronous to refclk
relock_req  in  1  single-cycle request to restart the sequence; clears FAIL
pll_reset  out  1  active-high reset to the PLL, registered
sys_reset  out  1  active-high system reset, registered; downstream domains synchronize it locally
locked  out  1  high only in RUN, registered
fail  out  1  high only in FAIL, registered
retry_cnt  out  4  number of timed-out attempts since the last success or relock_req

Behaviour:
- Reset values: state=S_RST, all counters 0, pll_reset=1, sys_reset=1, locked=0, fail=0, retry_cnt=0.
- extlock passes through a 2-flop synchronizer (lk_s). Response latency to an extlock edge is 2 cycles plus the FSM register.
- Outputs are registered decodes of next-state: pll_reset=(S_RST), sys_reset=!(S_RUN), locked=(S_RUN), fail=(S_FAIL).
- S_RST: rst_cnt increments each cycle. When rst_cnt==RST_CYC-1, go to S_WAIT and clear tmo_cnt. pll_reset is high for exactly RST_CYC cycles per entry, including the first entry after reset release.
- S_WAIT: tmo_cnt increments. If lk_s=1, go to S_STABLE with stb_cnt=0.
- S_STABLE: tmo_cnt keeps incrementing and stb_cnt increments.
  - If lk_s=0, go to S_WAIT, clear stb_cnt, do not clear tmo_cnt; lock flicker still times out.
  - If stb_cnt==STABLE_CYC-1 with lk_s=1, go to S_RUN and clear retry_cnt.
- Timeout applies in S_WAIT and S_STABLE: tmo_cnt==LOCK_TMO-1 takes priority over the lock transitions.
  - If retry_cnt+1==MAX_RETRY: retry_cnt saturates at MAX_RETRY and the FSM goes to S_FAIL.
  - Otherwise: retry_cnt increments and the FSM goes to S_RST.
- S_RUN: if lk_s=0, go to S_RST. sys_reset asserts on the next edge; retry_cnt is unchanged (0).
- S_FAIL: pll_reset=0, sys_reset=1. Only reset or relock_req exits.
- relock_req in any state: go to S_RST, clear retry_cnt and all counters. It has priority over every other transition, including a timeout in the same cycle.
- Lock loss coincident with relock_req in S_RUN: a single transition to S_RST.
- Asynchronous reset mid-sequence returns every register to its reset value immediately.
- Counter width is clog2(max(RST_CYC, LOCK_TMO, STABLE_CYC)). Counters never wrap, because every counter is cleared on the transition that ends its state.

Decomposition:
- Package sdc_pll_pkg:
  - state enum {S_RST, S_WAIT, S_STABLE, S_RUN, S_FAIL}, 3-bit encoding
  - RETRY_W=4
  - counter-width function
- One sub-module, sdc_sync2: a 2-flop synchronizer with async active-high reset to 0. It is instantiated for extlock.

Test Plan:
Benches use RST_CYC=4, LOCK_TMO=20, STABLE_CYC=8, MAX_RETRY=2.
1. Release reset; raise extlock 3 cycles after pll_reset falls and hold it high -> pll_reset high 4 cycles; sys_reset falls and locked rises 2+8+1 cycles after extlock rises; retry_cnt=0.
2. extlock stays 0 -> pll_reset pulses (4 cycles) at attempt start and again after 20 cycles; retry_cnt goes 0->1->2; the second timeout gives fail=1 and pll_reset=0, sys_reset=1 held.
3. From RUN, drop extlock for 1 cycle -> sys_reset=1 and locked=0 within 3 cycles; a new 4-cycle pll_reset pulse follows; re-lock completes with retry_cnt=0.
4. In S_STABLE, toggle extlock every 5 cycles -> never reaches RUN; timeout at tmo_cnt=19 increments retry_cnt.
5. In FAIL, pulse relock_req -> fail=0 and retry_cnt=0 next cycle; a fresh 4-cycle pll_reset pulse follows. Also fire relock_req in the same cycle as a timeout -> S_RST with retry_cnt=0, not FAIL.
6. Assert reset asynchronously mid-S_STABLE -> all outputs return to reset values before the next refclk edge.
